// File: rtl/gpu_pkg.sv
// gpu_pkg: definitions shared by the GPU 2D blocks.
//   - default framebuffer geometry and framebuffer address width
//   - register offsets of the rectangle-fill register file
//   - rectangle-fill FSM state encoding and register-file struct
//   - pix_index(): linear pixel index computed by shift-add
package gpu_pkg;

  localparam int unsigned FB_WIDTH_DEF  = 128;
  localparam int unsigned FB_HEIGHT_DEF = 96;
  localparam int unsigned FB_ADDR_W     = 14;

  localparam logic [2:0] REG_X     = 3'd0;
  localparam logic [2:0] REG_Y     = 3'd1;
  localparam logic [2:0] REG_W     = 3'd2;
  localparam logic [2:0] REG_H     = 3'd3;
  localparam logic [2:0] REG_COLOR = 3'd4;
  localparam logic [2:0] REG_CMD   = 3'd5;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SETUP = 2'd1,
    ST_FILL  = 2'd2
  } fill_state_t;

  typedef struct packed {
    logic [7:0] x;
    logic [7:0] y;
    logic [7:0] w;
    logic [7:0] h;
    logic [2:0] color;
  } rect_regs_t;

  // y*width+x with width a power of two: a shift and an add, no multiplier.
  function automatic logic [FB_ADDR_W-1:0] pix_index(input logic [7:0] x,
                                                     input logic [7:0] y,
                                                     input int unsigned log2w);
    return (FB_ADDR_W'(y) << log2w) + FB_ADDR_W'(x);
  endfunction

endpackage

// File: rtl/gpu_rect_fill.sv
// gpu_rect_fill: solid rectangle fill engine.
// A small register file (X, Y, W, H, COLOR, CMD) is written while idle; a
// CMD write with bit 0 set starts a fill. One SETUP cycle clips the
// rectangle to the framebuffer, then FILL streams one pixel write per
// accepted handshake in raster order (x innermost).
//
// Ports:
//   CLK        clock, rising edge
//   RESET      synchronous active-high reset
//   REG_WE     register write strobe
//   REG_ADDR   register select (0 X, 1 Y, 2 W, 3 H, 4 COLOR, 5 CMD)
//   REG_DATA   register write data
//   BUSY       fill in progress (start+1 until the DONE cycle)
//   DONE       one-cycle completion pulse
//   PIX_WE     pixel write request, held until PIX_READY
//   PIX_ADDR   linear pixel index y*FB_WIDTH+x
//   PIX_DATA   pixel colour {B,G,R}
//   PIX_READY  framebuffer accepts the pending write this cycle
module gpu_rect_fill
  import gpu_pkg::*;
#(
  parameter int unsigned FB_WIDTH  = FB_WIDTH_DEF,
  parameter int unsigned FB_HEIGHT = FB_HEIGHT_DEF
) (
  input  logic                 CLK,
  input  logic                 RESET,
  input  logic                 REG_WE,
  input  logic [2:0]           REG_ADDR,
  input  logic [7:0]           REG_DATA,
  output logic                 BUSY,
  output logic                 DONE,
  output logic                 PIX_WE,
  output logic [FB_ADDR_W-1:0] PIX_ADDR,
  output logic [2:0]           PIX_DATA,
  input  logic                 PIX_READY
);

  localparam int unsigned LOG2W = $clog2(FB_WIDTH);
  localparam logic [8:0]  FB_W9 = 9'(FB_WIDTH);
  localparam logic [8:0]  FB_H9 = 9'(FB_HEIGHT);

  fill_state_t          state_q;
  rect_regs_t           regs_q;
  logic [8:0]           xe_q, ye_q;   // exclusive clipped bounds
  logic [7:0]           x_q, y_q;     // current pixel
  logic                 busy_q, done_q, pix_we_q;
  logic [FB_ADDR_W-1:0] pix_addr_q;
  logic [2:0]           pix_data_q;

  logic [8:0] xsum_d, ysum_d, xe_d, ye_d, x_inc_d, y_inc_d;
  logic       empty_d, accept_d, last_x_d, last_y_d;

  always_comb begin
    // 9-bit sums so X+W cannot wrap before the clip.
    xsum_d   = {1'b0, regs_q.x} + {1'b0, regs_q.w};
    ysum_d   = {1'b0, regs_q.y} + {1'b0, regs_q.h};
    xe_d     = (xsum_d > FB_W9) ? FB_W9 : xsum_d;
    ye_d     = (ysum_d > FB_H9) ? FB_H9 : ysum_d;
    empty_d  = (regs_q.w == 8'd0) || (regs_q.h == 8'd0) ||
               ({1'b0, regs_q.x} >= FB_W9) || ({1'b0, regs_q.y} >= FB_H9);
    accept_d = pix_we_q && PIX_READY;
    x_inc_d  = {1'b0, x_q} + 9'd1;
    y_inc_d  = {1'b0, y_q} + 9'd1;
    last_x_d = (x_inc_d == xe_q);
    last_y_d = (y_inc_d == ye_q);
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q    <= ST_IDLE;
      regs_q     <= '0;
      xe_q       <= '0;
      ye_q       <= '0;
      x_q        <= '0;
      y_q        <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      pix_we_q   <= 1'b0;
      pix_addr_q <= '0;
      pix_data_q <= '0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (REG_WE) begin
            case (REG_ADDR)
              REG_X:     regs_q.x     <= REG_DATA;
              REG_Y:     regs_q.y     <= REG_DATA;
              REG_W:     regs_q.w     <= REG_DATA;
              REG_H:     regs_q.h     <= REG_DATA;
              REG_COLOR: regs_q.color <= REG_DATA[2:0];
              REG_CMD: begin
                if (REG_DATA[0]) begin
                  state_q <= ST_SETUP;
                  busy_q  <= 1'b1;
                end
              end
              default: ;
            endcase
          end
        end
        ST_SETUP: begin
          xe_q <= xe_d;
          ye_q <= ye_d;
          x_q  <= regs_q.x;
          y_q  <= regs_q.y;
          if (empty_d) begin
            state_q <= ST_IDLE;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
          end else begin
            state_q    <= ST_FILL;
            pix_we_q   <= 1'b1;
            pix_addr_q <= pix_index(regs_q.x, regs_q.y, LOG2W);
            pix_data_q <= regs_q.color;
          end
        end
        ST_FILL: begin
          // Address/data only move on acceptance, so they stay stable
          // across any number of stall cycles.
          if (accept_d) begin
            if (!last_x_d) begin
              x_q        <= x_inc_d[7:0];
              pix_addr_q <= pix_addr_q + 1'b1;
            end else if (!last_y_d) begin
              x_q        <= regs_q.x;
              y_q        <= y_inc_d[7:0];
              pix_addr_q <= pix_index(regs_q.x, y_inc_d[7:0], LOG2W);
            end else begin
              state_q  <= ST_IDLE;
              pix_we_q <= 1'b0;
              busy_q   <= 1'b0;
              done_q   <= 1'b1;
            end
          end
        end
        default: begin
          state_q  <= ST_IDLE;
          pix_we_q <= 1'b0;
          busy_q   <= 1'b0;
        end
      endcase
    end
  end

  assign BUSY     = busy_q;
  assign DONE     = done_q;
  assign PIX_WE   = pix_we_q;
  assign PIX_ADDR = pix_addr_q;
  assign PIX_DATA = pix_data_q;

endmodule

// File: tb/tb_gpu_rect_fill.sv
// Bench for gpu_rect_fill: directed timing cases plus randomized rectangles
// with random PIX_READY, checked against a loop-based raster model.
module tb_gpu_rect_fill;

  localparam int FBW = 128;
  localparam int FBH = 96;

  logic        CLK = 1'b0;
  logic        RESET;
  logic        REG_WE;
  logic [2:0]  REG_ADDR;
  logic [7:0]  REG_DATA;
  logic        BUSY, DONE, PIX_WE, PIX_READY;
  logic [13:0] PIX_ADDR;
  logic [2:0]  PIX_DATA;

  gpu_rect_fill dut (
    .CLK(CLK), .RESET(RESET), .REG_WE(REG_WE), .REG_ADDR(REG_ADDR),
    .REG_DATA(REG_DATA), .BUSY(BUSY), .DONE(DONE), .PIX_WE(PIX_WE),
    .PIX_ADDR(PIX_ADDR), .PIX_DATA(PIX_DATA), .PIX_READY(PIX_READY)
  );

  always #5 CLK = ~CLK;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  always @(posedge CLK) cyc <= cyc + 1;

  // Observation logs, sampled mid-cycle.
  int wr_addr_q[$];
  int wr_data_q[$];
  int wr_cyc_q[$];
  int done_cyc_q[$];
  int busy_cyc_q[$];
  int we_cnt;
  int exp_q[$];

  always @(negedge CLK) begin
    if (PIX_WE) we_cnt++;
    if (PIX_WE && PIX_READY) begin
      wr_addr_q.push_back(int'(PIX_ADDR));
      wr_data_q.push_back(int'(PIX_DATA));
      wr_cyc_q.push_back(cyc);
    end
    if (DONE) done_cyc_q.push_back(cyc);
    if (BUSY) busy_cyc_q.push_back(cyc);
  end

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic clear_logs();
    wr_addr_q.delete(); wr_data_q.delete(); wr_cyc_q.delete();
    done_cyc_q.delete(); busy_cyc_q.delete(); we_cnt = 0;
  endtask

  task automatic wr_reg(input logic [2:0] a, input logic [7:0] d);
    REG_WE = 1'b1; REG_ADDR = a; REG_DATA = d;
    tick();
    REG_WE = 1'b0;
  endtask

  task automatic prog(input int x, input int y, input int w, input int h, input int c);
    wr_reg(3'd0, 8'(x)); wr_reg(3'd1, 8'(y)); wr_reg(3'd2, 8'(w));
    wr_reg(3'd3, 8'(h)); wr_reg(3'd4, 8'(c));
  endtask

  // Reference: every pixel of the rectangle that lies inside the framebuffer.
  task automatic model_rect(input int x, input int y, input int w, input int h);
    int xe, ye;
    exp_q.delete();
    xe = (x + w < FBW) ? x + w : FBW;
    ye = (y + h < FBH) ? y + h : FBH;
    for (int yy = y; yy < ye; yy++)
      for (int xx = x; xx < xe; xx++)
        exp_q.push_back(yy * FBW + xx);
  endtask

  task automatic wait_done(input string nm, input int budget, input bit rnd);
    int k = 0;
    while (done_cyc_q.size() == 0 && k < budget) begin
      if (rnd) PIX_READY = ($urandom_range(0, 3) != 0);
      tick();
      k++;
    end
    PIX_READY = 1'b1;
    if (done_cyc_q.size() == 0) begin
      total++; bad++;
      $display("FAIL %s_timeout no DONE within %0d cycles", nm, budget);
    end
    repeat (3) tick();
  endtask

  task automatic test_reset();
    RESET = 1'b1; REG_WE = 1'b0; REG_ADDR = '0; REG_DATA = '0; PIX_READY = 1'b1;
    repeat (3) tick();
    total++;
    if ({BUSY, DONE, PIX_WE} !== 3'b000 || PIX_ADDR !== 14'd0 || PIX_DATA !== 3'd0) begin
      bad++;
      $display("FAIL reset_outputs got busy=%b done=%b we=%b addr=%0d data=%0d exp all 0",
               BUSY, DONE, PIX_WE, PIX_ADDR, PIX_DATA);
    end
    RESET = 1'b0;
    tick();
  endtask

  task automatic test_basic();
    int n;
    prog(10, 5, 3, 2, 5);
    model_rect(10, 5, 3, 2);
    clear_logs();
    n = cyc;
    wr_reg(3'd5, 8'd1);
    wait_done("basic", 40, 1'b0);
    total++;
    if (wr_addr_q.size() !== exp_q.size()) begin
      bad++; $display("FAIL basic_count got=%0d exp=%0d", wr_addr_q.size(), exp_q.size());
    end
    for (int i = 0; i < exp_q.size() && i < wr_addr_q.size(); i++) begin
      total++;
      if (wr_addr_q[i] !== exp_q[i] || wr_data_q[i] !== 5 || wr_cyc_q[i] !== n + 2 + i) begin
        bad++;
        $display("FAIL basic_write%0d got addr=%0d data=%0d cyc=%0d exp addr=%0d data=5 cyc=%0d",
                 i, wr_addr_q[i], wr_data_q[i], wr_cyc_q[i], exp_q[i], n + 2 + i);
      end
    end
    total++;
    if (done_cyc_q.size() !== 1 || done_cyc_q[0] !== n + 8) begin
      bad++; $display("FAIL basic_done got n=%0d first=%0d exp one at %0d",
                      done_cyc_q.size(), done_cyc_q.size() ? done_cyc_q[0] : -1, n + 8);
    end
    total++;
    if (busy_cyc_q.size() !== 7 || busy_cyc_q[0] !== n + 1 || busy_cyc_q[6] !== n + 7) begin
      bad++; $display("FAIL basic_busy got count=%0d exp 7 cycles %0d..%0d",
                      busy_cyc_q.size(), n + 1, n + 7);
    end
  endtask

  task automatic test_clip();
    prog(126, 94, 4, 4, 3);
    model_rect(126, 94, 4, 4);
    clear_logs();
    wr_reg(3'd5, 8'd1);
    wait_done("clip", 40, 1'b0);
    total++;
    if (wr_addr_q.size() !== 4 || we_cnt !== 4) begin
      bad++; $display("FAIL clip_count got=%0d we=%0d exp=4", wr_addr_q.size(), we_cnt);
    end
    for (int i = 0; i < exp_q.size() && i < wr_addr_q.size(); i++) begin
      total++;
      if (wr_addr_q[i] !== exp_q[i] || wr_data_q[i] !== 3) begin
        bad++; $display("FAIL clip_write%0d got addr=%0d data=%0d exp addr=%0d data=3",
                        i, wr_addr_q[i], wr_data_q[i], exp_q[i]);
      end
    end
  endtask

  task automatic test_empty(input string nm);
    int n;
    clear_logs();
    n = cyc;
    wr_reg(3'd5, 8'd1);
    wait_done(nm, 20, 1'b0);
    total++;
    if (we_cnt !== 0) begin
      bad++; $display("FAIL %s_we got=%0d exp=0", nm, we_cnt);
    end
    total++;
    if (busy_cyc_q.size() !== 1 || busy_cyc_q[0] !== n + 1) begin
      bad++; $display("FAIL %s_busy got count=%0d exp single cycle %0d", nm, busy_cyc_q.size(), n + 1);
    end
    total++;
    if (done_cyc_q.size() !== 1 || done_cyc_q[0] !== n + 2) begin
      bad++; $display("FAIL %s_done got n=%0d first=%0d exp %0d", nm, done_cyc_q.size(),
                      done_cyc_q.size() ? done_cyc_q[0] : -1, n + 2);
    end
  endtask

  task automatic test_zero_width();
    prog(10, 5, 0, 2, 5);
    test_empty("empty");
  endtask

  task automatic test_backpressure();
    int n;
    prog(10, 5, 3, 2, 5);
    model_rect(10, 5, 3, 2);
    clear_logs();
    n = cyc;
    wr_reg(3'd5, 8'd1);
    tick(); tick();               // now in cycle n+3, second write presented
    for (int s = 0; s < 3; s++) begin
      PIX_READY = 1'b0;
      total++;
      if (PIX_WE !== 1'b1 || PIX_ADDR !== 14'd651) begin
        bad++; $display("FAIL bp_hold%0d got we=%b addr=%0d exp we=1 addr=651", s, PIX_WE, PIX_ADDR);
      end
      tick();
    end
    PIX_READY = 1'b1;
    wait_done("bp", 40, 1'b0);
    total++;
    if (wr_addr_q.size() !== exp_q.size()) begin
      bad++; $display("FAIL bp_count got=%0d exp=%0d", wr_addr_q.size(), exp_q.size());
    end
    for (int i = 0; i < exp_q.size() && i < wr_addr_q.size(); i++) begin
      total++;
      if (wr_addr_q[i] !== exp_q[i]) begin
        bad++; $display("FAIL bp_write%0d got=%0d exp=%0d", i, wr_addr_q[i], exp_q[i]);
      end
    end
    total++;
    if (done_cyc_q.size() !== 1 || done_cyc_q[0] !== n + 11) begin
      bad++; $display("FAIL bp_done got first=%0d exp %0d",
                      done_cyc_q.size() ? done_cyc_q[0] : -1, n + 11);
    end
  endtask

  task automatic test_ignore_busy();
    prog(10, 5, 3, 2, 5);
    model_rect(10, 5, 3, 2);
    clear_logs();
    wr_reg(3'd5, 8'd1);
    wr_reg(3'd2, 8'd200);         // during SETUP
    wr_reg(3'd5, 8'd1);           // restart attempt during FILL
    wait_done("busy", 40, 1'b0);
    repeat (8) tick();
    total++;
    if (wr_addr_q.size() !== exp_q.size() || done_cyc_q.size() !== 1) begin
      bad++; $display("FAIL busy_ignore got writes=%0d dones=%0d exp writes=%0d dones=1",
                      wr_addr_q.size(), done_cyc_q.size(), exp_q.size());
    end
    for (int i = 0; i < exp_q.size() && i < wr_addr_q.size(); i++) begin
      total++;
      if (wr_addr_q[i] !== exp_q[i]) begin
        bad++; $display("FAIL busy_write%0d got=%0d exp=%0d", i, wr_addr_q[i], exp_q[i]);
      end
    end
  endtask

  task automatic test_reset_midfill();
    prog(10, 5, 3, 2, 5);
    clear_logs();
    wr_reg(3'd5, 8'd1);
    tick(); tick(); tick();       // cycle n+4: third write presented
    total++;
    if (PIX_WE !== 1'b1 || PIX_ADDR !== 14'd652) begin
      bad++; $display("FAIL rst_pre got we=%b addr=%0d exp we=1 addr=652", PIX_WE, PIX_ADDR);
    end
    RESET = 1'b1;
    tick();
    total++;
    if (PIX_WE !== 1'b0 || BUSY !== 1'b0 || DONE !== 1'b0 || PIX_ADDR !== 14'd0) begin
      bad++; $display("FAIL rst_abort got we=%b busy=%b done=%b addr=%0d exp 0 0 0 0",
                      PIX_WE, BUSY, DONE, PIX_ADDR);
    end
    RESET = 1'b0;
    clear_logs();
    repeat (8) tick();
    total++;
    if (we_cnt !== 0 || done_cyc_q.size() !== 0) begin
      bad++; $display("FAIL rst_quiet got we=%0d dones=%0d exp 0 0", we_cnt, done_cyc_q.size());
    end
    // Registers were cleared, so a bare start is a W=0 fill.
    test_empty("rst_readback");
  endtask

  task automatic test_random();
    int x, y, w, h, c;
    for (int it = 0; it < 20; it++) begin
      x = $urandom_range(0, 140); y = $urandom_range(0, 110);
      w = $urandom_range(0, 12);  h = $urandom_range(0, 6);
      c = $urandom_range(0, 7);
      if (it < 6) begin x = FBW - $urandom_range(1, 6); y = FBH - $urandom_range(1, 4); end
      prog(x, y, w, h, c);
      model_rect(x, y, w, h);
      clear_logs();
      wr_reg(3'd5, 8'd1);
      wait_done("rand", 1000, 1'b1);
      total++;
      if (wr_addr_q.size() !== exp_q.size() || done_cyc_q.size() !== 1) begin
        bad++; $display("FAIL rand%0d_count x=%0d y=%0d w=%0d h=%0d got=%0d dones=%0d exp=%0d",
                        it, x, y, w, h, wr_addr_q.size(), done_cyc_q.size(), exp_q.size());
      end
      for (int i = 0; i < exp_q.size() && i < wr_addr_q.size(); i++) begin
        total++;
        if (wr_addr_q[i] !== exp_q[i] || wr_data_q[i] !== c) begin
          bad++; $display("FAIL rand%0d_write%0d got addr=%0d data=%0d exp addr=%0d data=%0d",
                          it, i, wr_addr_q[i], wr_data_q[i], exp_q[i], c);
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_clip();
    test_zero_width();
    test_backpressure();
    test_ignore_busy();
    test_reset_midfill();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/gpu_rect_fill.md
GPU_RECT_FILL -- requirements
Module: gpu_rect_fill

Interface
REQ-001 SHALL have parameter FB_WIDTH, default 128: framebuffer width in pixels, a power of two.
REQ-002 SHALL have parameter FB_HEIGHT, default 96: framebuffer height in pixels.
REQ-003 SHALL have port CLK, input, 1 bit: the single clock; all logic is rising-edge.
REQ-004 SHALL have port RESET, input, 1 bit: synchronous, active-high reset.
REQ-005 SHALL have port REG_WE, input, 1 bit: register write strobe, one write per cycle.
REQ-006 SHALL have port REG_ADDR, input, 3 bits: register select (0 X, 1 Y, 2 W, 3 H, 4 COLOR, 5 CMD).
REQ-007 SHALL have port REG_DATA, input, 8 bits: register write data.
REQ-008 SHALL have port BUSY, output, 1 bit: fill in progress.
REQ-009 SHALL have port DONE, output, 1 bit: one-cycle completion pulse.
REQ-010 SHALL have port PIX_WE, output, 1 bit: pixel write request to the framebuffer write port.
REQ-011 SHALL have port PIX_ADDR, output, 14 bits: linear pixel index y*FB_WIDTH+x.
REQ-012 SHALL have port PIX_DATA, output, 3 bits: pixel colour, bit0 R, bit1 G, bit2 B.
REQ-013 SHALL have port PIX_READY, input, 1 bit: framebuffer accepts a pending write this cycle.

Function
REQ-014 SHALL store X, Y, W and H as 8 bits and COLOR as REG_DATA[2:0] when REG_WE is high in IDLE.
REQ-015 SHALL ignore every register write, including CMD, while BUSY is high.
REQ-016 SHALL treat a CMD write with REG_DATA[0]=1 in IDLE as start; a CMD write with REG_DATA[0]=0 has no effect.
REQ-017 SHALL implement the states IDLE, SETUP and FILL.
  - IDLE -> SETUP on start.
  - SETUP -> FILL when the clipped area is non-empty, otherwise SETUP -> IDLE.
  - FILL -> IDLE after the last write is accepted.
REQ-018 SHALL compute in SETUP the exclusive clipped bounds XE=min(X+W, FB_WIDTH) and YE=min(Y+H, FB_HEIGHT), using 9-bit sums.
REQ-019 SHALL treat the area as empty when W=0, H=0, X>=FB_WIDTH or Y>=FB_HEIGHT.
REQ-020 SHALL drive BUSY high from the cycle after start until the cycle DONE is asserted.
REQ-021 SHALL assert PIX_WE continuously in FILL and issue the first write in the cycle after SETUP, i.e. 2 cycles after start.
REQ-022 SHALL generate writes in raster order, x innermost, from (X,Y) to (XE-1,YE-1).
REQ-023 SHALL treat a write as accepted when PIX_WE and PIX_READY are both high on a rising edge.
REQ-024 SHALL hold PIX_ADDR and PIX_DATA stable while PIX_WE is high and PIX_READY is low.
REQ-025 SHALL advance to the next pixel only on acceptance, giving a sustained rate of 1 pixel per cycle.
REQ-026 SHALL, after the last acceptance, drop PIX_WE and BUSY and pulse DONE for 1 cycle, all on the next cycle.
REQ-027 SHALL pulse DONE in the cycle after SETUP for an empty area, with no PIX_WE.
REQ-028 SHALL keep PIX_WE low outside FILL.
REQ-029 SHALL form PIX_ADDR by shift-add with no multiplier.

Reset
REQ-030 SHALL, while RESET is high, force the state to IDLE and X, Y, W, H, COLOR, internal counters, BUSY, DONE, PIX_WE, PIX_ADDR and PIX_DATA to 0.
REQ-031 SHALL, on reset mid-fill, abort the fill with PIX_WE low at the first edge where RESET is sampled, no further writes and no DONE pulse.
REQ-032 SHALL give RESET priority over REG_WE and PIX_READY.

Structure
REQ-033 SHALL take FB_WIDTH, FB_HEIGHT, FB_ADDR_W=14, the register offsets and the state encoding from shared package gpu_pkg.
REQ-034 SHALL need no sub-module; the register file, bounds clip and address counter all sit inside gpu_rect_fill.

Verification
REQ-035 SHALL pass: X=10, Y=5, W=3, H=2, COLOR=5, PIX_READY=1, start at cycle n -> PIX_ADDR 650, 651, 652, 778, 779, 780 with data 5 in cycles n+2..n+7; BUSY high n+1..n+7; DONE at n+8.
REQ-036 SHALL pass: X=126, Y=94, W=4, H=4 -> exactly 4 writes, to 12158, 12159, 12286, 12287.
REQ-037 SHALL pass: W=0, start at n -> no PIX_WE; BUSY high at n+1 only; DONE at n+2.
REQ-038 SHALL pass: case REQ-035 with PIX_READY low for 3 cycles while PIX_ADDR=651 -> address 651 held throughout; same 6-write sequence; DONE delayed by 3 cycles.
REQ-039 SHALL pass: a W=200 write and a second start while BUSY -> ignored; the running fill is unchanged and only one DONE pulse occurs.
REQ-040 SHALL pass: RESET at the 3rd write of case REQ-035 -> PIX_WE low next edge; BUSY=0; a readback fill with W=0 behaves as REQ-037.
